// File: rtl/sm_regdump_pkg.sv
// sm_regdump_pkg -- shared constants for the schoolMIPS register-dump scanner.
//
// Holds the FSM state encodings, the header tag placed in front of each
// word, and the number of stream bytes per register word.
//
// Build option: define SM_REGDUMP_HEADER_EN to prefix every word with a
// header byte {3'b101, regAddr}, making each word 5 bytes instead of 4.
package sm_regdump_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_NEXT = 2'd3;

  localparam logic [2:0] HDR_TAG = 3'b101;

`ifdef SM_REGDUMP_HEADER_EN
  localparam int BYTES_PER_WORD = 5;
`else
  localparam int BYTES_PER_WORD = 4;
`endif

  localparam int WORD_W = BYTES_PER_WORD * 8;

endpackage

// File: rtl/sm_regdump_ser.sv
// sm_regdump_ser -- loadable word-to-byte serializer with valid/ready output.
//
// A load captures a whole frame and raises valid with the most significant
// byte on data_o. Each handshake (valid_o && ready_i) shifts to the next byte;
// the handshake on the final byte drops valid.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture word_i and start streaming (only issued while idle)
//   word_i    : frame to serialize, sent MSB byte first
//   ready_i   : sink ready
//   data_o    : current byte
//   valid_o   : data_o valid
//   last_o    : current byte is the final one of the frame
//   fire_o    : handshake happens on this edge
module sm_regdump_ser #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [BYTES*8-1:0] word_i,
  input  logic               ready_i,
  output logic [7:0]         data_o,
  output logic               valid_o,
  output logic               last_o,
  output logic               fire_o
);

  localparam int W  = BYTES * 8;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;

  assign data_o  = sreg_q[W-1 -: 8];
  assign valid_o = valid_q;
  assign fire_o  = valid_q & ready_i;
  assign last_o  = valid_q & (cnt_q == CW'(BYTES - 1));

  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      sreg_d  = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (fire_o) begin
      // Shifting in zeros leaves data_o at 0 once the frame is exhausted.
      sreg_d = sreg_q << 8;
      cnt_d  = cnt_q + CW'(1);
      if (last_o) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/sm_regdump.sv
// sm_regdump -- hardware register-dump scanner for the schoolMIPS debug port.
//
// On start, walks regAddr from ADDR_FIRST to ADDR_LAST, captures regData for
// each address and streams it as bytes (big-endian) over tx_data/tx_valid/
// tx_ready. Address 0 of the debug port returns the PC.
//
// Build option: SM_REGDUMP_HEADER_EN prefixes each word with {3'b101, regAddr}.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle dump request, ignored while busy or while done pulses
//   busy       : dump in progress
//   done       : one-cycle completion pulse
//   regAddr    : debug-port address to the CPU
//   regData    : debug-port data (combinational from regAddr)
//   tx_data    : stream byte
//   tx_valid   : stream byte valid
//   tx_ready   : sink ready
module sm_regdump
  import sm_regdump_pkg::*;
#(
  parameter int ADDR_FIRST = 0,
  parameter int ADDR_LAST  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  if (ADDR_FIRST < 0 || ADDR_FIRST > ADDR_LAST || ADDR_LAST > 31) begin : g_bad_range
    $error("sm_regdump: need 0 <= ADDR_FIRST <= ADDR_LAST <= 31");
  end

  localparam logic [4:0] FIRST_A = 5'(ADDR_FIRST);
  localparam logic [4:0] LAST_A  = 5'(ADDR_LAST);

  logic [1:0]        state_q, state_d;
  logic [4:0]        addr_q, addr_d;
  logic              done_q, done_d;
  logic              ser_load;
  logic              ser_last;
  logic              ser_fire;
  logic [WORD_W-1:0] frame;

`ifdef SM_REGDUMP_HEADER_EN
  assign frame = {HDR_TAG, addr_q, regData};
`else
  assign frame = regData;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    ser_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start in the done cycle belongs to the dump just finished.
        if (start && !done_q) begin
          state_d = ST_ADDR;
          addr_d  = FIRST_A;
        end
      end
      ST_ADDR: begin
        // regData has had a full cycle to settle after the address change.
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (ser_fire && ser_last) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (addr_q == LAST_A) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_q + 5'd1;
          state_d = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  sm_regdump_ser #(
    .BYTES (BYTES_PER_WORD)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .word_i  (frame),
    .ready_i (tx_ready),
    .data_o  (tx_data),
    .valid_o (tx_valid),
    .last_o  (ser_last),
    .fire_o  (ser_fire)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign regAddr = addr_q;

endmodule
